entity_slot_scheduler: RTL and testbench
========================================

// Module: entity_slot_scheduler
// PURPOSE
//  Arbitrates entity-record writes from several game-logic requesters (player, sword, dragon, HUD) into a shadow entity table.
//  At the start of vertical blanking it copies the shadow table into the live table, one slot per cycle.
//  The live table drives the picture processing unit's entity/dragon slot inputs, so on-screen sprites change only between frames, never mid-scan.
// PARAMETERS
//  NUM_REQ      4    number of requesters; round-robin arbitrated
//  NUM_SLOTS    16   entity slots in the shadow and live tables
//  ENT_W        15   record width: [14] disable, [13:10] ID, [9:8] orientation, [7:0] tile location
//  VBLANK_LINE  480  counter_V value that starts the commit
// PORTS
//  clk_in      in   1              pixel clock, 25 MHz
//  reset       in   1              synchronous, active-high
//  req_valid   in   NUM_REQ        bit i: requester i has a write pending
//  req_slot    in   NUM_REQ*4      requester i target slot at [i*4 +: 4]
//  req_data    in   NUM_REQ*ENT_W  requester i record at [i*ENT_W +: ENT_W]
//  req_ack     out  NUM_REQ        one-cycle pulse: requester i's write accepted
//  counter_V   in   10             VGA vertical pixel counter
//  slot_out    out  NUM_SLOTS*ENT_W live table; slot k at [k*ENT_W +: ENT_W]; top level maps k to PPU inputs
//  frame_commit out 1              one-cycle pulse when the live table has been fully updated
//  busy        out  1              high while the FSM is not in ACCEPT
// BEHAVIOUR
//  Reset: shadow and live slots = EMPTY (15'h3C00, ID 4'hF). req_ack=0, frame_commit=0, busy=0, rr_ptr=0, prev_V=0, state=ACCEPT.
//  Reset mid-COPY: commit is abandoned; live table returns to EMPTY.
//  Vblank edge: vb_edge = (counter_V==VBLANK_LINE) && (prev_V!=VBLANK_LINE). prev_V <= counter_V every cycle.
//  FSM ACCEPT:
//   - vb_edge -> COPY with copy_idx=0. No grant in that cycle; vb_edge beats requests.
//   - Otherwise grant at most one requester per cycle. Eligible: req_valid[i] && !req_ack[i], so a requester acked this cycle is masked.
//   - Search order: rr_ptr, rr_ptr+1, ... mod NUM_REQ. On a grant to g: shadow[req_slot_g] <= req_data_g, req_ack[g] <= 1 next cycle, rr_ptr <= (g+1) mod NUM_REQ.
//  FSM COPY: live[copy_idx] <= shadow[copy_idx]; copy_idx++. After idx NUM_SLOTS-1 -> DONE. Lasts NUM_SLOTS cycles.
//  FSM DONE: frame_commit=1 for this cycle only -> ACCEPT.
//  vb_edge in COPY or DONE is ignored.
//  No grants in COPY or DONE; req_ack stays 0. Pending requests wait, with no loss.
//  Handshake: the requester holds valid/slot/data stable until it sees ack. It may present a new request in the ack cycle, which is first eligible the next cycle.
//  Same-slot writes serialize; the later grant wins. Shadow writes never alter slot_out until COPY reaches that slot.
//  req_ack, frame_commit and busy are registered. slot_out is the live register array, with no combinational path from inputs.
//  Widths: copy_idx is $clog2(NUM_SLOTS) bits; rr_ptr wraps modulo NUM_REQ, also for non-power-of-2 NUM_REQ.
// STRUCTURE
//  Shared package ppu_pkg:
//   - ENT_W; EMPTY_ENTITY=15'h3C00
//   - entity field offsets (DIS_BIT, ID_MSB/LSB, OR_MSB/LSB, LOC_MSB/LSB)
//   - FSM encodings ST_ACCEPT/ST_COPY/ST_DONE
//  Sub-module rr_arbiter (NUM_REQ): inputs req mask and rr_ptr; outputs one-hot grant and a grant_valid flag; purely combinational.
//  The FSM, shadow/live tables, ack and pointer registers sit in this module.
// TESTING
//  1 Reset for 2 cycles -> every slot_out field = 15'h3C00; req_ack=0; frame_commit=0; busy=0.
//  2 req0 writes slot 3 with 15'h0123 -> req_ack=4'b0001 next cycle; slot_out slot 3 still 3C00.
//    Then drive counter_V 479->480 -> busy for 17 cycles; slot 3=0123; frame_commit pulses on the 17th cycle.
//  3 All four valid from reset, held -> acks 0001,0010,0100,1000 in 4 consecutive cycles, then 0001 again (round-robin wrap).
//  4 req1 (15'h0A05) and req2 (15'h0B05) both target slot 5, rr_ptr=0 -> req1 acked then req2.
//    After commit, slot 5 = 15'h0B05.
//  5 req3 valid in the vb_edge cycle and throughout COPY -> req_ack stays 0 for 17 cycles; req3 acked on the first ACCEPT cycle after DONE.
//  6 Assert reset in COPY at copy_idx=8 -> next cycle all slots = 3C00, busy=0, no frame_commit pulse.
//    A following vblank commits an all-EMPTY table.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: entity record layout, the empty-slot marker and the
// slot scheduler's FSM encoding.
package ppu_pkg;

    localparam int ENT_W = 15;

    // ID 4'hF marks a slot the PPU must not draw.
    localparam logic [ENT_W-1:0] EMPTY_ENTITY = 15'h3C00;

    localparam int DIS_BIT = 14;
    localparam int ID_MSB  = 13;
    localparam int ID_LSB  = 10;
    localparam int OR_MSB  = 9;
    localparam int OR_LSB  = 8;
    localparam int LOC_MSB = 7;
    localparam int LOC_LSB = 0;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_COPY   = 2'd1,
        ST_DONE   = 2'd2
    } sched_state_t;

    function automatic logic [ENT_W-1:0] make_entity(
        input logic       dis,
        input logic [3:0] id,
        input logic [1:0] orient,
        input logic [7:0] loc
    );
        logic [ENT_W-1:0] e;
        e = '0;
        e[DIS_BIT]         = dis;
        e[ID_MSB:ID_LSB]   = id;
        e[OR_MSB:OR_LSB]   = orient;
        e[LOC_MSB:LOC_LSB] = loc;
        return e;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// rr_ptr (wrapping modulo NUM_REQ) and returns it one-hot.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid
);

    // Search offsets k = 0..NUM_REQ-1 from the pointer; the wrap is an explicit
    // subtraction so non-power-of-2 requester counts rotate correctly.
    always_comb begin
        int target;
        grant       = '0;
        grant_valid = 1'b0;
        target      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            target = int'(rr_ptr) + k;
            if (target >= NUM_REQ) begin
                target = target - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_valid && req[i] && (i == target)) begin
                    grant[i]    = 1'b1;
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/entity_slot_scheduler.sv
// Collects entity-record writes into a shadow table and copies it into the
// live table at the start of vblank, so sprites only change between frames.
module entity_slot_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_SLOTS   = 16,
    parameter int ENT_W       = ppu_pkg::ENT_W,
    parameter int VBLANK_LINE = 480
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*4-1:0]       req_slot,
    input  logic [NUM_REQ*ENT_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic [9:0]                 counter_V,
    output logic [NUM_SLOTS*ENT_W-1:0] slot_out,
    output logic                       frame_commit,
    output logic                       busy
);
    import ppu_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [ENT_W-1:0] EMPTY   = ENT_W'(EMPTY_ENTITY);
    localparam logic [9:0]       VB_LINE = 10'(VBLANK_LINE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    sched_state_t     state;
    logic [IDX_W-1:0] copy_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic [9:0]       prev_V;
    logic [ENT_W-1:0] shadow [NUM_SLOTS];
    logic [ENT_W-1:0] live   [NUM_SLOTS];

    logic               vb_edge;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [3:0]         win_slot;
    logic [ENT_W-1:0]   win_data;

    assign vb_edge = (counter_V == VB_LINE) && (prev_V != VB_LINE);

    // A requester whose ack is showing this cycle is still holding its old
    // request on the bus, so it must not be granted a second time.
    assign eligible = req_valid & ~req_ack;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arbiter (
        .req         (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        win_slot  = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                win_slot  = req_slot[i*4 +: 4];
                win_data  = req_data[i*ENT_W +: ENT_W];
            end
        end
        next_ptr = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
    end

    // A vblank edge seen in ACCEPT wins over any pending request that cycle;
    // edges arriving while a commit is already running are dropped.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= ST_ACCEPT;
            copy_idx     <= '0;
            rr_ptr       <= '0;
            prev_V       <= '0;
            req_ack      <= '0;
            frame_commit <= 1'b0;
            busy         <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                shadow[k] <= EMPTY;
                live[k]   <= EMPTY;
            end
        end else begin
            prev_V       <= counter_V;
            req_ack      <= '0;
            frame_commit <= 1'b0;
            case (state)
                ST_ACCEPT: begin
                    if (vb_edge) begin
                        state    <= ST_COPY;
                        copy_idx <= '0;
                        busy     <= 1'b1;
                    end else if (grant_valid) begin
                        shadow[win_slot] <= win_data;
                        req_ack          <= grant;
                        rr_ptr           <= next_ptr;
                    end
                end
                ST_COPY: begin
                    live[copy_idx] <= shadow[copy_idx];
                    copy_idx       <= copy_idx + 1'b1;
                    if (copy_idx == LAST_IDX) begin
                        state        <= ST_DONE;
                        frame_commit <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_ACCEPT;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_ACCEPT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        slot_out = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_out[k*ENT_W +: ENT_W] = live[k];
        end
    end

endmodule

// File: tb/tb_entity_slot_scheduler.sv
// Testbench for entity_slot_scheduler: directed vector table, a reset-mid-commit
// sequence, and randomized traffic checked against a table-level model.
module tb_entity_slot_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int NUM_SLOTS = 16;
    localparam int ENT_W     = 15;
    localparam logic [14:0]  EMPTY = 15'h3C00;
    localparam logic [239:0] ALL_EMPTY = {16{15'h3C00}};

    logic         clk_in = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [15:0]  req_slot;
    logic [59:0]  req_data;
    logic [3:0]   req_ack;
    logic [9:0]   counter_V;
    logic [239:0] slot_out;
    logic         frame_commit;
    logic         busy;

    always #5 clk_in = ~clk_in;

    entity_slot_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .NUM_SLOTS   (NUM_SLOTS),
        .ENT_W       (ENT_W),
        .VBLANK_LINE (480)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_slot     (req_slot),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .counter_V    (counter_V),
        .slot_out     (slot_out),
        .frame_commit (frame_commit),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [9:0]  cv;
        logic [3:0]  exp_ack;
        logic        exp_busy;
        logic        exp_fc;
        int          probe;
        logic [14:0] exp_probe;
    } vec_t;

    vec_t vecs[$];

    // Reference model: tables as arrays, commit progress as a countdown of
    // remaining busy cycles, arbitration as a plain modulo search.
    logic [14:0] m_shadow [16];
    logic [14:0] m_live   [16];
    logic [3:0]  m_ack;
    logic        m_busy;
    logic        m_fc;
    int          m_ptr;
    int          m_prev;
    int          m_left;

    task automatic checkVal(input string name, input logic [239:0] act, input logic [239:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic modelStep();
        logic [3:0] elig;
        logic [3:0] next_ack;
        bit         vb;
        int         i;
        int         pos;
        if (reset) begin
            for (int s = 0; s < 16; s++) begin
                m_shadow[s] = EMPTY;
                m_live[s]   = EMPTY;
            end
            m_ack = '0; m_busy = 0; m_fc = 0;
            m_ptr = 0;  m_prev = 0; m_left = 0;
            return;
        end
        vb       = (counter_V == 10'd480) && (m_prev != 480);
        m_prev   = int'(counter_V);
        next_ack = '0;
        m_fc     = 0;
        if (m_left == 0) begin
            if (vb) begin
                m_left = NUM_SLOTS + 1;
            end else begin
                elig = req_valid & ~m_ack;
                for (int k = 0; k < NUM_REQ; k++) begin
                    i = (m_ptr + k) % NUM_REQ;
                    if (elig[i]) begin
                        m_shadow[req_slot[i*4 +: 4]] = req_data[i*15 +: 15];
                        next_ack[i] = 1'b1;
                        m_ptr = (i + 1) % NUM_REQ;
                        break;
                    end
                end
            end
        end else begin
            pos = NUM_SLOTS + 1 - m_left;
            if (pos < NUM_SLOTS) m_live[pos] = m_shadow[pos];
            m_left--;
            m_fc = (m_left == 1);
        end
        m_ack  = next_ack;
        m_busy = (m_left != 0);
    endtask

    function automatic logic [239:0] modelImage();
        logic [239:0] img;
        for (int s = 0; s < 16; s++) img[s*15 +: 15] = m_live[s];
        return img;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [9:0] cv);
        reset     = rst;
        req_valid = valid;
        counter_V = cv;
        modelStep();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input int cyc);
        checkVal($sformatf("rand%0d ack", cyc),  240'(req_ack),      240'(m_ack));
        checkVal($sformatf("rand%0d busy", cyc), 240'(busy),         240'(m_busy));
        checkVal($sformatf("rand%0d fc", cyc),   240'(frame_commit), 240'(m_fc));
        checkVal($sformatf("rand%0d slots", cyc), slot_out, modelImage());
    endtask

    function automatic void addVec(input logic rst, input logic [3:0] valid, input int cv,
                                   input logic [3:0] ack, input logic bsy, input logic fc,
                                   input int probe, input logic [14:0] val);
        vec_t v;
        v.rst = rst; v.valid = valid; v.cv = 10'(cv);
        v.exp_ack = ack; v.exp_busy = bsy; v.exp_fc = fc;
        v.probe = probe; v.exp_probe = val;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] pend;
        logic       seen_fc;
        int         fc_cycle;
        int         busy_cnt;

        reset     = 1'b1;
        req_valid = '0;
        counter_V = '0;
        req_slot  = {4'd9, 4'd5, 4'd5, 4'd3};
        req_data  = {15'h0C09, 15'h0B05, 15'h0A05, 15'h0123};

        // Directed table: slot3/slot5 writes, commit, blocked request, rr wrap.
        addVec(1, 4'b0000, 0,   4'b0000, 0, 0, 3, EMPTY);
        addVec(1, 4'b0000, 0,   4'b0000, 0, 0, 3, EMPTY);
        addVec(0, 4'b0001, 0,   4'b0001, 0, 0, 3, EMPTY);
        addVec(0, 4'b0000, 0,   4'b0000, 0, 0, 3, EMPTY);
        addVec(0, 4'b0110, 0,   4'b0010, 0, 0, 3, EMPTY);
        addVec(0, 4'b0100, 0,   4'b0100, 0, 0, 3, EMPTY);
        addVec(0, 4'b0000, 479, 4'b0000, 0, 0, 3, EMPTY);
        addVec(0, 4'b1000, 480, 4'b0000, 1, 0, 3, EMPTY);
        for (int n = 8; n <= 22; n++) begin
            if (n <= 10)      addVec(0, 4'b1000, 480, 4'b0000, 1, 0, 3, EMPTY);
            else if (n == 11) addVec(0, 4'b1000, 480, 4'b0000, 1, 0, 3, 15'h0123);
            else if (n == 12) addVec(0, 4'b1000, 480, 4'b0000, 1, 0, 5, EMPTY);
            else              addVec(0, 4'b1000, 480, 4'b0000, 1, 0, 5, 15'h0B05);
        end
        addVec(0, 4'b1000, 480, 4'b0000, 1, 1, 5, 15'h0B05);
        addVec(0, 4'b1000, 480, 4'b0000, 0, 0, 5, 15'h0B05);
        addVec(0, 4'b1000, 480, 4'b1000, 0, 0, 9, EMPTY);
        addVec(0, 4'b0000, 480, 4'b0000, 0, 0, 3, 15'h0123);
        addVec(1, 4'b0000, 0,   4'b0000, 0, 0, 3, EMPTY);
        addVec(0, 4'b1111, 0,   4'b0001, 0, 0, 3, EMPTY);
        addVec(0, 4'b1111, 0,   4'b0010, 0, 0, 3, EMPTY);
        addVec(0, 4'b1111, 0,   4'b0100, 0, 0, 3, EMPTY);
        addVec(0, 4'b1111, 0,   4'b1000, 0, 0, 3, EMPTY);
        addVec(0, 4'b1111, 0,   4'b0001, 0, 0, 3, EMPTY);
        addVec(0, 4'b0000, 0,   4'b0000, 0, 0, 5, EMPTY);

        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n].rst, vecs[n].valid, vecs[n].cv);
            checkVal($sformatf("vec%0d ack", n),  240'(req_ack),      240'(vecs[n].exp_ack));
            checkVal($sformatf("vec%0d busy", n), 240'(busy),         240'(vecs[n].exp_busy));
            checkVal($sformatf("vec%0d fc", n),   240'(frame_commit), 240'(vecs[n].exp_fc));
            checkVal($sformatf("vec%0d slot%0d", n, vecs[n].probe),
                     240'(slot_out[vecs[n].probe*15 +: 15]), 240'(vecs[n].exp_probe));
        end

        // Reset at copy_idx 8 abandons the commit; the next vblank commits EMPTY.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(0, 4'b0001, 0);
        checkVal("rst_copy grant", 240'(req_ack), 240'(4'b0001));
        applyStimulus(0, 4'b0000, 479);
        applyStimulus(0, 4'b0000, 480);
        checkVal("rst_copy busy", 240'(busy), 240'(1'b1));
        for (int c = 0; c < 8; c++) applyStimulus(0, 4'b0000, 480);
        checkVal("rst_copy partial slot3", 240'(slot_out[3*15 +: 15]), 240'(15'h0123));
        applyStimulus(1, 4'b0000, 0);
        checkVal("rst_copy slots", slot_out, ALL_EMPTY);
        checkVal("rst_copy busy0", 240'(busy), 240'(1'b0));
        checkVal("rst_copy fc0", 240'(frame_commit), 240'(1'b0));
        seen_fc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(0, 4'b0000, 0);
            if (frame_commit !== 1'b0 || busy !== 1'b0) seen_fc = 1'b1;
        end
        checkVal("rst_copy idle after reset", 240'(seen_fc), 240'(1'b0));
        applyStimulus(0, 4'b0000, 479);
        fc_cycle = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 17; c++) begin
            applyStimulus(0, 4'b0000, 480);
            if (busy === 1'b1) busy_cnt++;
            if (frame_commit === 1'b1) fc_cycle = c;
        end
        checkVal("empty_commit busy cycles", 240'(busy_cnt), 240'(17));
        checkVal("empty_commit fc cycle", 240'(fc_cycle), 240'(17));
        applyStimulus(0, 4'b0000, 480);
        checkVal("empty_commit busy end", 240'(busy), 240'(1'b0));
        checkVal("empty_commit slots", slot_out, ALL_EMPTY);

        // Randomized traffic against the model, requesters obeying the handshake.
        applyStimulus(1, 4'b0000, 0);
        applyStimulus(1, 4'b0000, 0);
        pend = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i] === 1'b1) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    req_slot[i*4 +: 4]   = 4'($urandom_range(0, 15));
                    req_data[i*15 +: 15] = 15'($urandom);
                end
            end
            applyStimulus(($urandom_range(0, 299) == 0),
                          pend,
                          ($urandom_range(0, 7) == 0) ? 10'd480 : 10'd479);
            checkOutput(cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
